otter_mem_arbiter: RTL and testbench



---
 rtl/otter_arb_pkg.sv | 36 +++
 rtl/otter_arb_starve_ctr.sv | 46 ++++
 rtl/otter_mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_otter_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_arb_pkg.sv
// -----------------------------------------------------------------------------
// otter_arb_pkg
// Shared types for the Otter memory data-port arbiter (port 2).
//   state_t : arbiter sequencing states (IDLE, RD_CPU, RD_DMA)
//   owner_t : which requester owns the current memory access
//   size_t  : access size encoding (SZ_BYTE / SZ_HALF / SZ_WORD)
//   mem_req_t : one requester's access attributes, bundled for muxing
// -----------------------------------------------------------------------------
package otter_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_CPU = 2'd1,
        RD_DMA = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    typedef logic [1:0] size_t;

    localparam size_t SZ_BYTE = 2'd0;
    localparam size_t SZ_HALF = 2'd1;
    localparam size_t SZ_WORD = 2'd2;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] din;
        size_t       size;
        logic        sign;
    } mem_req_t;

endpackage

// File: rtl/otter_arb_starve_ctr.sv
// -----------------------------------------------------------------------------
// otter_arb_starve_ctr
// DMA starvation counter for the fair-arbitration build. Counts arbitration
// cycles in which DMA asked but the CPU won, saturating at STARVE_MAX. While
// the count equals STARVE_MAX, force_dma tells the arbiter to let DMA win.
// Only present when OTTER_ARB_FAIR_EN is defined; the default build leaves
// this file empty.
//
// Ports:
//   CLK       in   clock, rising edge
//   RST_N     in   synchronous active-low reset (clears the count)
//   inc       in   DMA denied this cycle (IDLE, DMA_REQ, CPU won)
//   clr       in   DMA granted this cycle
//   force_dma out  count has reached STARVE_MAX
// -----------------------------------------------------------------------------
`ifdef OTTER_ARB_FAIR_EN
module otter_arb_starve_ctr #(
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic inc,
    input  logic clr,
    output logic force_dma
);

    localparam logic [7:0] LIMIT = 8'(STARVE_MAX);

    logic [7:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIMIT)) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign force_dma = (cnt == LIMIT);

endmodule
`endif

// File: rtl/otter_mem_arbiter.sv
// -----------------------------------------------------------------------------
// otter_mem_arbiter
// Two-requester arbiter for the Otter memory data port (MEM_*2). Shares the
// synchronous-read port between the CPU load/store path and a DMA/debug
// master. A store completes at its grant edge; a load is granted in IDLE and
// its data is steered back to the owner one cycle later (RD_CPU / RD_DMA).
// The grant path is combinational from REQ; MEM_DOUT2 only feeds the DOUTs.
//
// Build option:
//   OTTER_ARB_FAIR_EN  defined   : starvation counter gives DMA forced
//                                  priority after STARVE_MAX denied cycles
//                      undefined : fixed CPU priority, STARVE_MAX unused
//
// Ports:
//   CLK, RST_N                         clock, synchronous active-low reset
//   CPU_REQ/WE/ADDR/DIN/SIZE/SIGN      CPU access request + attributes
//   CPU_GNT, CPU_RVALID, CPU_DOUT      CPU grant, load-data valid, load data
//   DMA_*                              same, DMA side
//   MEM_RDEN2, MEM_WE2                 memory read/write strobes
//   MEM_ADDR2, MEM_DIN2                memory address / write data
//   MEM_SIZE, MEM_SIGN                 access attributes to memory
//   MEM_DOUT2                          memory read data (cycle after RDEN)
//   BUSY                               a read is in flight
// -----------------------------------------------------------------------------
module otter_mem_arbiter
    import otter_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        CLK,
    input  logic        RST_N,

    input  logic        CPU_REQ,
    input  logic        CPU_WE,
    input  logic [31:0] CPU_ADDR,
    input  logic [31:0] CPU_DIN,
    input  logic [1:0]  CPU_SIZE,
    input  logic        CPU_SIGN,
    output logic        CPU_GNT,
    output logic        CPU_RVALID,
    output logic [31:0] CPU_DOUT,

    input  logic        DMA_REQ,
    input  logic        DMA_WE,
    input  logic [31:0] DMA_ADDR,
    input  logic [31:0] DMA_DIN,
    input  logic [1:0]  DMA_SIZE,
    input  logic        DMA_SIGN,
    output logic        DMA_GNT,
    output logic        DMA_RVALID,
    output logic [31:0] DMA_DOUT,

    output logic        MEM_RDEN2,
    output logic        MEM_WE2,
    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT2,

    output logic        BUSY
);

    state_t   state;
    state_t   state_nxt;
    logic     force_dma;
    logic     dma_wins;
    logic     cpu_wins;
    owner_t   win_owner;
    mem_req_t cpu_attr;
    mem_req_t dma_attr;
    mem_req_t win_attr;

    // -------------------------------------------------------------------------
    // Optional fairness: DMA gets forced priority once starved long enough.
    // -------------------------------------------------------------------------
`ifdef OTTER_ARB_FAIR_EN
    logic starve_inc;

    // Counts only real arbitration cycles, so a reset cycle never increments.
    assign starve_inc = RST_N && (state == IDLE) && cpu_wins && DMA_REQ;

    otter_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .inc       (starve_inc),
        .clr       (DMA_GNT),
        .force_dma (force_dma)
    );
`else
    localparam int unsigned unused_starve_max = STARVE_MAX;
    assign force_dma = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Winner selection: CPU by default, DMA when alone or when forced.
    // -------------------------------------------------------------------------
    assign cpu_attr  = '{we: CPU_WE, addr: CPU_ADDR, din: CPU_DIN,
                         size: CPU_SIZE, sign: CPU_SIGN};
    assign dma_attr  = '{we: DMA_WE, addr: DMA_ADDR, din: DMA_DIN,
                         size: DMA_SIZE, sign: DMA_SIGN};

    assign dma_wins  = DMA_REQ && (!CPU_REQ || force_dma);
    assign cpu_wins  = CPU_REQ && !dma_wins;
    assign win_owner = dma_wins ? OWN_DMA : OWN_CPU;
    assign win_attr  = (win_owner == OWN_DMA) ? dma_attr : cpu_attr;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: reset is synchronous: it is only looked at inside the clocked
    // process, so RST_N never appears in the sensitivity list.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case leaves a variable unassigned (which would infer a latch).
        state_nxt  = state;
        CPU_GNT    = 1'b0;
        CPU_RVALID = 1'b0;
        CPU_DOUT   = '0;
        DMA_GNT    = 1'b0;
        DMA_RVALID = 1'b0;
        DMA_DOUT   = '0;
        MEM_RDEN2  = 1'b0;
        MEM_WE2    = 1'b0;
        MEM_ADDR2  = '0;
        MEM_DIN2   = '0;
        MEM_SIZE   = '0;
        MEM_SIGN   = 1'b0;
        BUSY       = 1'b0;

        if (!RST_N) begin
            // Outputs stay at their zero defaults; an in-flight read is dropped.
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_wins || dma_wins) begin
                        CPU_GNT   = cpu_wins;
                        DMA_GNT   = dma_wins;
                        MEM_RDEN2 = ~win_attr.we;
                        MEM_WE2   = win_attr.we;
                        MEM_ADDR2 = win_attr.addr;
                        MEM_DIN2  = win_attr.din;
                        MEM_SIZE  = win_attr.size;
                        MEM_SIGN  = win_attr.sign;
                        // Stores finish at the grant edge; loads wait a cycle.
                        if (!win_attr.we) begin
                            state_nxt = (win_owner == OWN_DMA) ? RD_DMA : RD_CPU;
                        end
                    end
                end

                RD_CPU: begin
                    BUSY       = 1'b1;
                    CPU_RVALID = 1'b1;
                    CPU_DOUT   = MEM_DOUT2;
                    state_nxt  = IDLE;
                end

                RD_DMA: begin
                    BUSY       = 1'b1;
                    DMA_RVALID = 1'b1;
                    DMA_DOUT   = MEM_DOUT2;
                    state_nxt  = IDLE;
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_otter_mem_arbiter
// Self-checking bench for otter_mem_arbiter. Directed scenarios followed by a
// randomized phase; every cycle all outputs are compared with a reference
// model built from the arbitration rules (pending-read queue + starvation
// count). Honours OTTER_ARB_FAIR_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_otter_mem_arbiter;

    localparam int unsigned STARVE_MAX = 3;
`ifdef OTTER_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        CPU_REQ, CPU_WE, CPU_SIGN;
    logic [31:0] CPU_ADDR, CPU_DIN;
    logic [1:0]  CPU_SIZE;
    logic        CPU_GNT, CPU_RVALID;
    logic [31:0] CPU_DOUT;
    logic        DMA_REQ, DMA_WE, DMA_SIGN;
    logic [31:0] DMA_ADDR, DMA_DIN;
    logic [1:0]  DMA_SIZE;
    logic        DMA_GNT, DMA_RVALID;
    logic [31:0] DMA_DOUT;
    logic        MEM_RDEN2, MEM_WE2, MEM_SIGN;
    logic [31:0] MEM_ADDR2, MEM_DIN2, MEM_DOUT2;
    logic [1:0]  MEM_SIZE;
    logic        BUSY;

    otter_mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN),
        .CPU_SIZE(CPU_SIZE), .CPU_SIGN(CPU_SIGN),
        .CPU_GNT(CPU_GNT), .CPU_RVALID(CPU_RVALID), .CPU_DOUT(CPU_DOUT),
        .DMA_REQ(DMA_REQ), .DMA_WE(DMA_WE), .DMA_ADDR(DMA_ADDR), .DMA_DIN(DMA_DIN),
        .DMA_SIZE(DMA_SIZE), .DMA_SIGN(DMA_SIGN),
        .DMA_GNT(DMA_GNT), .DMA_RVALID(DMA_RVALID), .DMA_DOUT(DMA_DOUT),
        .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2),
        .MEM_DIN2(MEM_DIN2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
        .MEM_DOUT2(MEM_DOUT2), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // ---------------------------------------------------------------- checking
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------- reference model
    // rd_q  : owners (1 = CPU, 2 = DMA) of loads granted and not yet returned
    // starve: arbitration cycles DMA has lost in a row (fair build only)
    // win   : requester granted in the cycle just sampled (0 = none)
    int   rd_q[$];
    int   starve = 0;
    int   win    = 0;
    logic win_we = 1'b0;

    task automatic sample();
        logic        e_cgnt, e_dgnt, e_crv, e_drv, e_rden, e_we, e_sign, e_busy;
        logic [31:0] e_cdout, e_ddout, e_addr, e_din;
        logic [1:0]  e_size;
        @(negedge CLK);
        {e_cgnt, e_dgnt, e_crv, e_drv, e_rden, e_we, e_sign, e_busy} = '0;
        {e_cdout, e_ddout, e_addr, e_din, e_size} = '0;
        win    = 0;
        win_we = 1'b0;
        if (RST_N !== 1'b1) begin
            // reset cycle: everything reads zero
        end else if (rd_q.size() != 0) begin
            e_busy = 1'b1;
            if (rd_q[0] == 1) begin e_crv = 1'b1; e_cdout = MEM_DOUT2; end
            else              begin e_drv = 1'b1; e_ddout = MEM_DOUT2; end
        end else begin
            if (DMA_REQ && (!CPU_REQ || (FAIR && starve >= int'(STARVE_MAX)))) win = 2;
            else if (CPU_REQ) win = 1;
            if (win == 1) begin
                e_cgnt = 1'b1; win_we = CPU_WE;
                {e_addr, e_din, e_size, e_sign} = {CPU_ADDR, CPU_DIN, CPU_SIZE, CPU_SIGN};
            end else if (win == 2) begin
                e_dgnt = 1'b1; win_we = DMA_WE;
                {e_addr, e_din, e_size, e_sign} = {DMA_ADDR, DMA_DIN, DMA_SIZE, DMA_SIGN};
            end
            if (win != 0) begin e_we = win_we; e_rden = ~win_we; end
        end
        check("cpu_gnt",    32'(CPU_GNT),    32'(e_cgnt));
        check("dma_gnt",    32'(DMA_GNT),    32'(e_dgnt));
        check("cpu_rvalid", 32'(CPU_RVALID), 32'(e_crv));
        check("dma_rvalid", 32'(DMA_RVALID), 32'(e_drv));
        check("cpu_dout",   CPU_DOUT,        e_cdout);
        check("dma_dout",   DMA_DOUT,        e_ddout);
        check("mem_rden2",  32'(MEM_RDEN2),  32'(e_rden));
        check("mem_we2",    32'(MEM_WE2),    32'(e_we));
        check("mem_addr2",  MEM_ADDR2,       e_addr);
        check("mem_din2",   MEM_DIN2,        e_din);
        check("mem_size",   32'(MEM_SIZE),   32'(e_size));
        check("mem_sign",   32'(MEM_SIGN),   32'(e_sign));
        check("busy",       32'(BUSY),       32'(e_busy));
    endtask

    task automatic advance();
        @(posedge CLK);
        if (RST_N !== 1'b1) begin
            rd_q.delete();
            starve = 0;
        end else if (rd_q.size() != 0) begin
            void'(rd_q.pop_front());
        end else begin
            if (win != 0 && !win_we) rd_q.push_back(win);
            if (win == 2) starve = 0;
            else if (win == 1 && DMA_REQ && starve < int'(STARVE_MAX)) starve++;
        end
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    // --------------------------------------------------------- stimulus helpers
    task automatic set_cpu(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] din, input logic [1:0] size, input logic sign);
        CPU_REQ = req; CPU_WE = we; CPU_ADDR = addr; CPU_DIN = din;
        CPU_SIZE = size; CPU_SIGN = sign;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] din, input logic [1:0] size, input logic sign);
        DMA_REQ = req; DMA_WE = we; DMA_ADDR = addr; DMA_DIN = din;
        DMA_SIZE = size; DMA_SIGN = sign;
    endtask

    // ------------------------------------------------------------------ main
    initial begin
        int first_dma;

        RST_N     = 1'b0;
        MEM_DOUT2 = 32'h0;
        set_cpu(1'b1, 1'b0, 32'h44, 32'h0, 2'd2, 1'b0);
        set_dma(1'b1, 1'b1, 32'h88, 32'h5, 2'd2, 1'b0);
        @(posedge CLK); #1;

        // Reset with requests pending: all outputs zero.
        repeat (3) tick();
        RST_N = 1'b1;
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
        set_dma(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
        tick();

        // CPU load 0x100 alone.
        set_cpu(1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
        sample();
        check("t1_cpu_gnt", 32'(CPU_GNT), 32'd1);
        check("t1_rden",    32'(MEM_RDEN2), 32'd1);
        check("t1_addr",    MEM_ADDR2, 32'h100);
        advance();
        CPU_REQ   = 1'b0;
        MEM_DOUT2 = 32'hDEADBEEF;
        sample();
        check("t1_cpu_rvalid", 32'(CPU_RVALID), 32'd1);
        check("t1_cpu_dout",   CPU_DOUT, 32'hDEADBEEF);
        check("t1_dma_rvalid", 32'(DMA_RVALID), 32'd0);
        advance();

        // Simultaneous CPU store 0x10 and DMA load 0x20.
        set_cpu(1'b1, 1'b1, 32'h10, 32'hA5A5_0001, 2'd2, 1'b0);
        set_dma(1'b1, 1'b0, 32'h20, 32'h0, 2'd1, 1'b1);
        sample();
        check("t2_cpu_gnt", 32'(CPU_GNT), 32'd1);
        check("t2_we",      32'(MEM_WE2), 32'd1);
        check("t2_dma_gnt", 32'(DMA_GNT), 32'd0);
        advance();
        CPU_REQ = 1'b0;
        sample();
        check("t2_dma_gnt_n1", 32'(DMA_GNT), 32'd1);
        check("t2_addr_n1",    MEM_ADDR2, 32'h20);
        advance();
        DMA_REQ   = 1'b0;
        MEM_DOUT2 = 32'h1234_5678;
        sample();
        check("t2_dma_rvalid", 32'(DMA_RVALID), 32'd1);
        check("t2_dma_dout",   DMA_DOUT, 32'h1234_5678);
        advance();

        // DMA load in flight, CPU request arrives during RD_DMA.
        set_dma(1'b1, 1'b0, 32'h40, 32'h0, 2'd2, 1'b0);
        tick();
        DMA_REQ = 1'b0;
        set_cpu(1'b1, 1'b0, 32'h44, 32'h0, 2'd0, 1'b1);
        MEM_DOUT2 = 32'h0BAD_F00D;
        sample();
        check("t3_cpu_gnt_rd", 32'(CPU_GNT), 32'd0);
        check("t3_busy",       32'(BUSY), 32'd1);
        advance();
        sample();
        check("t3_cpu_gnt_next", 32'(CPU_GNT), 32'd1);
        advance();
        CPU_REQ = 1'b0;
        tick();

        // Reset during RD_CPU: read discarded, next request granted at once.
        set_cpu(1'b1, 1'b0, 32'h80, 32'h0, 2'd2, 1'b0);
        tick();
        set_cpu(1'b1, 1'b0, 32'h88, 32'h0, 2'd2, 1'b0);
        RST_N     = 1'b0;
        MEM_DOUT2 = 32'hFFFF_FFFF;
        sample();
        check("t4_cpu_rvalid_rst", 32'(CPU_RVALID), 32'd0);
        check("t4_cpu_dout_rst",   CPU_DOUT, 32'd0);
        check("t4_addr_rst",       MEM_ADDR2, 32'd0);
        advance();
        RST_N = 1'b1;
        sample();
        check("t4_cpu_gnt_post", 32'(CPU_GNT), 32'd1);
        check("t4_busy_post",    32'(BUSY), 32'd0);
        advance();
        CPU_REQ = 1'b0;
        tick();

        // Starvation: CPU stores every cycle with DMA_REQ held.
        first_dma = 0;
        set_dma(1'b1, 1'b1, 32'h200, 32'h55, 2'd2, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            set_cpu(1'b1, 1'b1, 32'h300 + 32'(4 * i), $urandom, 2'd2, 1'b0);
            sample();
            if (DMA_GNT === 1'b1 && first_dma == 0) first_dma = i;
            advance();
            if (win == 2) DMA_REQ = 1'b0;
        end
        check("t5_first_dma_gnt_cycle", 32'(first_dma), FAIR ? 32'd4 : 32'd0);
        CPU_REQ = 1'b0;
        tick();
        DMA_REQ = 1'b0;
        tick();

        // Randomized traffic; requesters hold REQ and attributes until granted.
        for (int i = 0; i < 500; i++) begin
            MEM_DOUT2 = $urandom;
            RST_N     = ($urandom_range(0, 99) != 0);
            tick();
            if (win == 1 || !CPU_REQ)
                set_cpu($urandom_range(0, 9) < 7, 1'($urandom), $urandom, $urandom,
                        2'($urandom_range(0, 2)), 1'($urandom));
            if (win == 2 || !DMA_REQ)
                set_dma($urandom_range(0, 9) < 5, 1'($urandom), $urandom, $urandom,
                        2'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
